// File: rtl/nic_ring_pkg.sv
// Shared definitions for the ring NIC host controller.
//   - NIC register-port addresses (input/output buffer and status)
//   - 64-bit ring packet field positions. The packet is described with bit 0
//     as the MSB, so MSB-0 bit k lives at vector index 63-k.
//   - Controller FSM state and arbitration grant enums
//   - build_packet(): assembles a packet from its fields
package nic_ring_pkg;

  localparam logic [1:0] INPUT_BUFFER  = 2'b00;
  localparam logic [1:0] INPUT_STATUS  = 2'b01;
  localparam logic [1:0] OUTPUT_BUFFER = 2'b10;
  localparam logic [1:0] OUTPUT_STATUS = 2'b11;

  localparam int PKT_W        = 64;
  localparam int PKT_VC_BIT   = 63;  // MSB-0 bit 0
  localparam int PKT_DIR_BIT  = 62;  // MSB-0 bit 1
  localparam int PKT_RSV_MSB  = 61;  // MSB-0 bits 2..7, always zero
  localparam int PKT_RSV_LSB  = 56;
  localparam int PKT_HOP_MSB  = 55;  // MSB-0 bits 8..15
  localparam int PKT_HOP_LSB  = 48;
  localparam int PKT_SRC_MSB  = 47;  // MSB-0 bits 16..31
  localparam int PKT_SRC_LSB  = 32;
  localparam int PKT_DATA_MSB = 31;  // MSB-0 bits 32..63
  localparam int PKT_DATA_LSB = 0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    OST_RD  = 3'd1,
    OST_CHK = 3'd2,
    OB_WR   = 3'd3,
    IST_RD  = 3'd4,
    IST_CHK = 3'd5,
    IB_RD   = 3'd6,
    IB_CAP  = 3'd7
  } nic_state_e;

  typedef enum logic {
    GRANT_TX = 1'b0,
    GRANT_RX = 1'b1
  } grant_e;

  function automatic logic [PKT_W-1:0] build_packet(
    input logic        vc,
    input logic        dir,
    input logic [7:0]  hop,
    input logic [15:0] src,
    input logic [31:0] data
  );
    logic [PKT_W-1:0] pkt;
    pkt                            = '0;
    pkt[PKT_VC_BIT]                = vc;
    pkt[PKT_DIR_BIT]               = dir;
    pkt[PKT_HOP_MSB:PKT_HOP_LSB]   = hop;
    pkt[PKT_SRC_MSB:PKT_SRC_LSB]   = src;
    pkt[PKT_DATA_MSB:PKT_DATA_LSB] = data;
    return pkt;
  endfunction

endpackage

// File: rtl/nic_host_ctrl_if.sv
// Bundle of the host-controller's TX request, RX stream and NIC port signals.
//   master modport : the controller (nic_host_ctrl)
//   slave modport  : the environment (request source, consumer and NIC)
// Signals:
//   tx_valid/tx_ready/tx_dst/tx_vc/tx_data : send request stream
//   tx_err                                 : drop pulse for self-addressed sends
//   rx_valid/rx_ready/rx_src/rx_data       : received packet stream
//   nic_addr/nic_d_in/nic_d_out/nic_en/nic_wr_en : NIC register port
//   dbg_state                              : controller FSM state (observation only)
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both 1. valid may not depend combinationally on ready; once raised, the
// producer holds valid and its payload until the transfer completes.
interface nic_host_ctrl_if;
  import nic_ring_pkg::*;

  logic        tx_valid;
  logic        tx_ready;
  logic [1:0]  tx_dst;
  logic        tx_vc;
  logic [31:0] tx_data;
  logic        tx_err;

  logic        rx_valid;
  logic        rx_ready;
  logic [15:0] rx_src;
  logic [31:0] rx_data;

  logic [1:0]  nic_addr;
  logic [63:0] nic_d_in;
  logic [63:0] nic_d_out;
  logic        nic_en;
  logic        nic_wr_en;

  nic_state_e  dbg_state;

  modport master (
    input  tx_valid, tx_dst, tx_vc, tx_data, rx_ready, nic_d_out,
    output tx_ready, tx_err, rx_valid, rx_src, rx_data,
           nic_addr, nic_d_in, nic_en, nic_wr_en, dbg_state
  );

  modport slave (
    output tx_valid, tx_dst, tx_vc, tx_data, rx_ready, nic_d_out,
    input  tx_ready, tx_err, rx_valid, rx_src, rx_data,
           nic_addr, nic_d_in, nic_en, nic_wr_en, dbg_state
  );

endinterface

// File: rtl/ring_route_calc.sv
// Combinational route computation for a 4-node ring.
//   src_i  : this node's position
//   dst_i  : destination node
//   dir_o  : 0 = clockwise, 1 = counter-clockwise
//   hop_o  : thermometer-coded hop count (01 = one hop, 03 = two hops)
//   self_o : destination equals source (no route)
// Going the short way round never needs more than two hops; the two-hop case
// takes dir=0 by convention of the ring.
module ring_route_calc (
  input  logic [1:0] src_i,
  input  logic [1:0] dst_i,
  output logic       dir_o,
  output logic [7:0] hop_o,
  output logic       self_o
);

  logic [1:0] rel;

  always_comb begin
    rel    = dst_i - src_i;  // 2-bit subtraction gives the mod-4 distance
    dir_o  = 1'b0;
    hop_o  = 8'h00;
    self_o = 1'b0;
    case (rel)
      2'd0: self_o = 1'b1;
      2'd1: hop_o  = 8'h01;
      2'd2: hop_o  = 8'h03;
      default: begin
        dir_o = 1'b1;
        hop_o = 8'h01;
      end
    endcase
  end

endmodule

// File: rtl/nic_host_ctrl.sv
// Host-side sequencer for one ring NIC's 4-register port.
//   clk, reset : clock and synchronous active-high reset
//   bus        : nic_host_ctrl_if.master (TX requests, RX stream, NIC port)
//   tx_count, rx_count : packet counters, present only when the macro
//                        NIC_HOST_CTRL_STATS_EN is defined
// A send request is captured into a one-entry TX holding register together
// with its fully built ring packet. The FSM shares the single NIC port between
// TX (poll output status, then write the output buffer) and RX (poll input
// status, then read the input buffer into the RX holding register),
// alternating when both sides want the port.
module nic_host_ctrl
  import nic_ring_pkg::*;
#(
  parameter int NODE_ID   = 0,
  parameter int RING_SIZE = 4
) (
  input logic             clk,
  input logic             reset,
  nic_host_ctrl_if.master bus
`ifdef NIC_HOST_CTRL_STATS_EN
  ,
  output logic [15:0]     tx_count,
  output logic [15:0]     rx_count
`endif
);

  localparam logic [1:0] NODE_POS = 2'(NODE_ID % RING_SIZE);

  nic_state_e  state_q, state_d;
  grant_e      last_grant_q, grant_d;
  logic        tx_pending_q, tx_pending_d;
  logic [63:0] tx_pkt_q, tx_pkt_d;
  logic        tx_err_q, tx_err_d;
  logic        rx_valid_q, rx_valid_d;
  logic [15:0] rx_src_q, rx_src_d;
  logic [31:0] rx_data_q, rx_data_d;

  logic        route_dir;
  logic [7:0]  route_hop;
  logic        route_self;
  logic        tx_accept;
  logic        tx_req, rx_req;
  logic        tx_done, rx_cap;
  logic        nic_en, nic_wr_en;
  logic [1:0]  nic_addr;
  logic [63:0] nic_d_in;

  ring_route_calc u_route (
    .src_i  (NODE_POS),
    .dst_i  (bus.tx_dst),
    .dir_o  (route_dir),
    .hop_o  (route_hop),
    .self_o (route_self)
  );

  assign tx_accept = bus.tx_valid && !tx_pending_q;
  assign tx_req    = tx_pending_q;
  // RX is only requested when the holding register is empty, so a capture
  // can never collide with a pop and no polling happens while a packet waits.
  assign rx_req    = !rx_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_RX;  // first contested grant after reset goes to TX
      tx_pending_q <= 1'b0;
      tx_pkt_q     <= '0;
      tx_err_q     <= 1'b0;
      rx_valid_q   <= 1'b0;
      rx_src_q     <= '0;
      rx_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= grant_d;
      tx_pending_q <= tx_pending_d;
      tx_pkt_q     <= tx_pkt_d;
      tx_err_q     <= tx_err_d;
      rx_valid_q   <= rx_valid_d;
      rx_src_q     <= rx_src_d;
      rx_data_q    <= rx_data_d;
    end
  end

  // Next-state and NIC port outputs. A status read is issued in *_RD and its
  // data is looked at one cycle later in *_CHK / IB_CAP.
  always_comb begin
    state_d   = state_q;
    grant_d   = last_grant_q;
    nic_en    = 1'b0;
    nic_wr_en = 1'b0;
    nic_addr  = INPUT_BUFFER;
    nic_d_in  = '0;
    tx_done   = 1'b0;
    rx_cap    = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_req && (!rx_req || last_grant_q == GRANT_RX)) begin
          state_d = OST_RD;
          grant_d = GRANT_TX;
        end else if (rx_req) begin
          state_d = IST_RD;
          grant_d = GRANT_RX;
        end
      end
      OST_RD: begin
        nic_en   = 1'b1;
        nic_addr = OUTPUT_STATUS;
        state_d  = OST_CHK;
      end
      OST_CHK: begin
        // Nonzero means the NIC output buffer is still full: give up the port
        // and retry on a later grant.
        state_d = (bus.nic_d_out == '0) ? OB_WR : IDLE;
      end
      OB_WR: begin
        nic_en    = 1'b1;
        nic_wr_en = 1'b1;
        nic_addr  = OUTPUT_BUFFER;
        nic_d_in  = tx_pkt_q;
        tx_done   = 1'b1;
        state_d   = IDLE;
      end
      IST_RD: begin
        nic_en   = 1'b1;
        nic_addr = INPUT_STATUS;
        state_d  = IST_CHK;
      end
      IST_CHK: begin
        state_d = (bus.nic_d_out != '0) ? IB_RD : IDLE;
      end
      IB_RD: begin
        nic_en   = 1'b1;
        nic_addr = INPUT_BUFFER;
        state_d  = IB_CAP;
      end
      IB_CAP: begin
        rx_cap  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // TX and RX holding registers.
  always_comb begin
    tx_pending_d = tx_pending_q;
    tx_pkt_d     = tx_pkt_q;
    tx_err_d     = 1'b0;
    if (tx_done) begin
      tx_pending_d = 1'b0;
    end
    // Accept only happens with the holding register empty, so it never
    // overlaps tx_done.
    if (tx_accept) begin
      if (route_self) begin
        tx_err_d = 1'b1;
      end else begin
        tx_pending_d = 1'b1;
        tx_pkt_d     = build_packet(bus.tx_vc, route_dir, route_hop,
                                    {14'd0, NODE_POS}, bus.tx_data);
      end
    end

    rx_valid_d = rx_valid_q;
    rx_src_d   = rx_src_q;
    rx_data_d  = rx_data_q;
    if (rx_cap) begin
      rx_valid_d = 1'b1;
      rx_src_d   = bus.nic_d_out[PKT_SRC_MSB:PKT_SRC_LSB];
      rx_data_d  = bus.nic_d_out[PKT_DATA_MSB:PKT_DATA_LSB];
    end else if (rx_valid_q && bus.rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  assign bus.tx_ready  = !tx_pending_q;
  assign bus.tx_err    = tx_err_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.rx_src    = rx_src_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.nic_en    = nic_en;
  assign bus.nic_wr_en = nic_wr_en;
  assign bus.nic_addr  = nic_addr;
  assign bus.nic_d_in  = nic_d_in;
  assign bus.dbg_state = state_q;

`ifdef NIC_HOST_CTRL_STATS_EN
  logic [15:0] tx_count_q, tx_count_d;
  logic [15:0] rx_count_q, rx_count_d;

  always_comb begin
    tx_count_d = tx_count_q;
    rx_count_d = rx_count_q;
    if (tx_done) tx_count_d = tx_count_q + 16'd1;  // wraps at 16'hFFFF
    if (rx_cap)  rx_count_d = rx_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_count_q <= '0;
      rx_count_q <= '0;
    end else begin
      tx_count_q <= tx_count_d;
      rx_count_q <= rx_count_d;
    end
  end

  assign tx_count = tx_count_q;
  assign rx_count = rx_count_q;
`endif

endmodule

// File: doc/nic_host_ctrl.md
Name: nic_host_ctrl

Overview:
- Host-side sequencer for one ring NIC's 4-register port (input buffer, input status, output buffer, output status).
- Accepts send requests (destination node and 32-bit payload) and builds the 64-bit ring packet header: vc, dir, hop, source.
- Polls output status before writing a packet, and polls input status before reading one.
- Delivers received packets on a valid/ready stream, arbitrating the single NIC port between TX and RX work.

Parameters:
- NODE_ID, 0, this node's ring position (0..3); written into the source field and used for route computation.
- RING_SIZE, 4, node count; fixed at 4 (hop encoding depends on it).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- tx_valid  in  1  send request valid
- tx_ready  out  1  TX holding register empty
- tx_dst  in  2  destination node
- tx_vc  in  1  virtual channel for the packet
- tx_data  in  32  payload
- tx_err  out  1  one-cycle pulse: request dropped because tx_dst == NODE_ID
- rx_valid  out  1  received packet available
- rx_ready  in  1  consumer accepts
- rx_src  out  16  source field of received packet
- rx_data  out  32  payload of received packet
- nic_addr  out  2  00 input buffer, 01 input status, 10 output buffer, 11 output status
- nic_d_in  out  64  packet bits [0:63] to NIC
- nic_d_out  in  64  NIC read data
- nic_en  out  1  NIC access strobe
- nic_wr_en  out  1  write qualifier

Behaviour:
- Reset values: tx_ready=1, tx_err=0, rx_valid=0, rx_src=0, rx_data=0, nic_en=0, nic_wr_en=0, nic_addr=00, nic_d_in=0. FSM returns to IDLE; pending TX and RX holding registers are cleared. Reset mid-transaction discards both.
- TX capture: tx_valid&tx_ready registers the request; tx_ready falls the next cycle.
  - If tx_dst==NODE_ID: nothing is held, tx_err pulses for one cycle, tx_ready stays 1.
- Packet build (bit 0 = MSB), with rel=(tx_dst-NODE_ID) mod 4:
  - [0] = tx_vc; [2:7] = 0; [16:31] = NODE_ID zero-extended; [32:63] = tx_data.
  - rel=1: dir[1]=0, hop[8:15]=8'h01.
  - rel=2: dir=0, hop=8'h03 (thermometer code).
  - rel=3: dir=1, hop=8'h01.
- NIC read timing: the controller drives addr with nic_en=1, nic_wr_en=0 in cycle N. nic_d_out is sampled in cycle N+1. Status encoding: 0 = output buffer empty / no input; nonzero = full / input present.
- NIC write timing: one cycle with nic_en=1, nic_wr_en=1, nic_addr=10, nic_d_in=packet.
- nic_en and nic_wr_en are 0 in every cycle not listed above.
- FSM states: IDLE, OST_RD, OST_CHK, OB_WR, IST_RD, IST_CHK, IB_RD, IB_CAP.
  - IDLE: tx_req = TX pending; rx_req = RX holding empty.
    - Both requests: grant the side not granted last; the first grant after reset goes to TX.
    - Only one request: grant it.
  - TX path: OST_RD -> OST_CHK.
    - Status 0 -> OB_WR -> IDLE; TX pending clears and tx_ready=1 the next cycle.
    - Status nonzero -> IDLE (retry later; grant toggles).
  - RX path: IST_RD -> IST_CHK.
    - Status nonzero -> IB_RD -> IB_CAP, which latches rx_src=[16:31] and rx_data=[32:63], sets rx_valid, then -> IDLE.
    - Status 0 -> IDLE.
- While rx_valid=1 and rx_ready=0, no input-status polling occurs.
- rx_valid&rx_ready clears rx_valid the next cycle. A capture cannot coincide with a pop, because RX is only granted when the holding register is empty.
- Best-case latency:
  - TX request to NIC write: 4 cycles.
  - Input present to rx_valid: 5 cycles.

Optional Feature:
- Macro NIC_HOST_CTRL_STATS_EN.
- Defined: adds output ports tx_count[15:0] and rx_count[15:0], reset 0. tx_count increments on each OB_WR; rx_count on each IB_CAP. Both wrap at 16'hFFFF->0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package nic_ring_pkg: register-address constants (INPUT_BUFFER etc.), packet field bit positions, and the FSM state enum.
- Sub-module ring_route_calc: combinational; (src, dst) -> dir, hop[7:0], self flag.

Test Plan:
- NODE_ID=0, tx_dst=1, tx_vc=0, tx_data=32'h0000_00AA, output status 0 -> write with nic_d_in=64'h0001_0000_0000_00AA, 4 cycles after acceptance.
- NODE_ID=0, tx_dst=3 -> dir=1, hop=01. tx_dst=2 -> dir=0, hop=03. tx_vc=1 sets bit 0.
- Output status held nonzero for 3 polls, then 0 -> exactly one write, no write before status 0, tx_ready reasserts after the write.
- Input status 1, input buffer 64'h0000_0002_DEAD_BEEF -> rx_valid, rx_src=2, rx_data=DEADBEEF. With rx_ready=0, no nic_addr=01 access until a pop occurs.
- TX pending while RX is free and input is present -> grants alternate TX, RX, TX. tx_dst=NODE_ID -> tx_err pulse and no NIC access. Reset during OB_WR-bound sequence -> all outputs at reset values next cycle.
